// File: rtl/perceptron_layer_ctrl_if.sv
// Handshake and configuration bundle for perceptron_layer_ctrl:
// shadow-bank write port, input sample channel and result channel.
interface perceptron_layer_ctrl_if #(
    parameter int N_NEURONS = 6,
    parameter int IN_W      = 4,
    parameter int BIAS_W    = 6
);
    logic                 cfg_valid;
    logic [1:0]           cfg_sel;
    logic [2:0]           cfg_idx;
    logic [BIAS_W-1:0]    cfg_data;
    logic                 cfg_commit;
    logic                 cfg_loaded;

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_W-1:0]      in_x1;
    logic [IN_W-1:0]      in_x2;

    logic                 out_valid;
    logic                 out_ready;
    logic [N_NEURONS-1:0] out_y;

    modport master (
        output cfg_valid, cfg_sel, cfg_idx, cfg_data, cfg_commit,
        output in_valid, in_x1, in_x2, out_ready,
        input  cfg_loaded, in_ready, out_valid, out_y
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_idx, cfg_data, cfg_commit,
        input  in_valid, in_x1, in_x2, out_ready,
        output cfg_loaded, in_ready, out_valid, out_y
    );
endinterface

// File: rtl/perceptron_layer_ctrl.sv
// Sequencer and configuration controller for the perceptron layer.
// Weights/biases are staged in a shadow bank and copied to the active bank
// (which drives the flat buses) only when no evaluation is in flight.
module perceptron_layer_ctrl #(
    parameter int N_NEURONS = 6,
    parameter int IN_W      = 4,
    parameter int BIAS_W    = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    perceptron_layer_ctrl_if.slave        bus,
    output logic [IN_W-1:0]               x1,
    output logic [IN_W-1:0]               x2,
    output logic [N_NEURONS*IN_W-1:0]     w1_flat,
    output logic [N_NEURONS*IN_W-1:0]     w2_flat,
    output logic [N_NEURONS*BIAS_W-1:0]   bias_flat,
    input  logic [N_NEURONS-1:0]          layer_y
);

    typedef enum logic [1:0] {
        UNCONFIG,
        READY,
        EVAL,
        HOLD
    } state_t;

    state_t state, state_nx;

    logic [N_NEURONS*IN_W-1:0]   sh_w1;
    logic [N_NEURONS*IN_W-1:0]   sh_w2;
    logic [N_NEURONS*BIAS_W-1:0] sh_bias;

    logic commit_pend;
    logic accept;
    logic capture;
    logic release_res;
    logic copy_now;
    logic pend_set;

    assign bus.in_ready = (state == READY);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNCONFIG;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-edge control strobes.
    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        copy_now    = 1'b0;
        pend_set    = 1'b0;
        unique case (state)
            UNCONFIG: begin
                if (bus.cfg_commit) begin
                    copy_now = 1'b1;
                    state_nx = READY;
                end
            end
            READY: begin
                copy_now = bus.cfg_commit;
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    state_nx = EVAL;
                end
            end
            EVAL: begin
                pend_set = bus.cfg_commit;
                capture  = 1'b1;
                state_nx = HOLD;
            end
            HOLD: begin
                pend_set = bus.cfg_commit;
                if (bus.out_ready) begin
                    // A commit arriving on the release edge merges with the
                    // pending one and is applied at that same edge.
                    release_res = 1'b1;
                    copy_now    = commit_pend | bus.cfg_commit;
                    state_nx    = READY;
                end
            end
            default: state_nx = UNCONFIG;
        endcase
    end

    // Shadow bank writes; out-of-range index or cfg_sel=3 writes nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_w1   <= '0;
            sh_w2   <= '0;
            sh_bias <= '0;
        end else if (bus.cfg_valid) begin
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                if (bus.cfg_idx == 3'(i)) begin
                    case (bus.cfg_sel)
                        2'd0:    sh_w1[i*IN_W +: IN_W]       <= bus.cfg_data[IN_W-1:0];
                        2'd1:    sh_w2[i*IN_W +: IN_W]       <= bus.cfg_data[IN_W-1:0];
                        2'd2:    sh_bias[i*BIAS_W +: BIAS_W] <= bus.cfg_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Active bank copy; reads shadow before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w1_flat        <= '0;
            w2_flat        <= '0;
            bias_flat      <= '0;
            bus.cfg_loaded <= 1'b0;
        end else if (copy_now) begin
            w1_flat        <= sh_w1;
            w2_flat        <= sh_w2;
            bias_flat      <= sh_bias;
            bus.cfg_loaded <= 1'b1;
        end
    end

    // Deferred commit flag for commits requested during an evaluation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pend <= 1'b0;
        end else if (copy_now) begin
            commit_pend <= 1'b0;
        end else if (pend_set) begin
            commit_pend <= 1'b1;
        end
    end

    // Sample capture, result capture and result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1            <= '0;
            x2            <= '0;
            bus.out_y     <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            if (accept) begin
                x1 <= bus.in_x1;
                x2 <= bus.in_x2;
            end
            if (capture) begin
                bus.out_y     <= layer_y;
                bus.out_valid <= 1'b1;
            end else if (release_res) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule
